// File: rtl/my_loader_pkg.sv
// Shared types and constants for the Hack ROM boot loader.
package my_loader_pkg;

    localparam int SUM_W  = 16;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA_HI,
        DATA_LO,
        SUM_HI,
        SUM_LO,
        DONE,
        ERROR
    } loader_state_t;

    // True in every state that still expects bytes from the stream.
    function automatic logic is_receive(input loader_state_t s);
        return (s != DONE) && (s != ERROR);
    endfunction

endpackage

// File: rtl/my_rom_loader.sv
// Boot loader: receives a length-prefixed, checksummed big-endian word image
// over a byte handshake, writes it into the instruction ROM and releases the
// CPU from reset only once the whole image has been verified.
module my_rom_loader
    import my_loader_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [WORD_W-1:0] rom_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    // Largest word count the ROM can hold; computed wide so any ADDR_W works.
    localparam logic [31:0] MAX_WORDS = (32'd1 << ADDR_W) - 32'd1;

    loader_state_t     state_q, state_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       count_q, count_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              live_q, live_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [WORD_W-1:0] rom_data_q, rom_data_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept;
    logic [WORD_W-1:0] word;
    logic              last_word;

    // live_q keeps in_ready low while reset is asserted and until the first
    // clock after release; reload also blocks the byte offered in its cycle.
    assign in_ready  = live_q && is_receive(state_q) && !reload;
    assign accept    = in_valid && in_ready;
    assign word      = {hi_q, in_data};
    assign last_word = (32'(index_q) + 32'd1) == 32'(count_q);

    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_data  = rom_data_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

    // Next-state logic: reload wins, otherwise each accepted byte advances the FSM.
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        count_d     = count_q;
        index_d     = index_q;
        sum_d       = sum_q;
        live_d      = 1'b1;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_data_d  = rom_data_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;

        if (reload) begin
            state_d     = HDR_HI;
            index_d     = '0;
            sum_d       = '0;
            done_d      = 1'b0;
            error_d     = 1'b0;
            cpu_reset_d = 1'b1;
        end else if (accept) begin
            case (state_q)
                HDR_HI: begin
                    hi_d    = in_data;
                    state_d = HDR_LO;
                end
                HDR_LO: begin
                    count_d = word;
                    if (word == 16'd0 || {16'd0, word} > MAX_WORDS) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
                DATA_HI: begin
                    hi_d    = in_data;
                    state_d = DATA_LO;
                end
                DATA_LO: begin
                    rom_we_d   = 1'b1;
                    rom_addr_d = index_q;
                    rom_data_d = word;
                    sum_d      = sum_q + word;
                    index_d    = index_q + ADDR_W'(1);
                    state_d    = last_word ? SUM_HI : DATA_HI;
                end
                SUM_HI: begin
                    hi_d    = in_data;
                    state_d = SUM_LO;
                end
                SUM_LO: begin
                    if (word == sum_q) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HDR_HI;
            hi_q        <= '0;
            count_q     <= '0;
            index_q     <= '0;
            sum_q       <= '0;
            live_q      <= 1'b0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_data_q  <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            count_q     <= count_d;
            index_q     <= index_d;
            sum_q       <= sum_d;
            live_q      <= live_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_data_q  <= rom_data_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_my_rom_loader.sv
// Self-checking bench for my_rom_loader: directed boot-image scenarios plus
// randomized images, checked against a byte-stream level reference model.
module tb_my_rom_loader;

    localparam int ADDR_W = 15;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [15:0] word_q_t[$];

    logic              clk;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              reload;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              cpu_reset;
    logic              done;
    logic              error;

    int num_checks = 0;
    int num_errors = 0;

    logic [31:0] obs_q[$];
    byte_q_t     tmp_b;
    word_q_t     tmp_w;

    my_rom_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reload    (reload),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every ROM write seen between clock edges as {addr, data}.
    always @(negedge clk) begin
        if (reset === 1'b1 && rom_we === 1'b1)
            obs_q.push_back({1'b0, rom_addr, rom_data});
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Offer each byte with optional random idle cycles; returns at the negedge
    // right after the last byte has been accepted.
    task automatic applyStimulus(input byte_q_t bytes, input int gap_pct);
        int waited;
        foreach (bytes[i]) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = bytes[i];
            waited   = 0;
            while (in_ready !== 1'b1 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (in_ready !== 1'b1) begin
                checkOutput("ready_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            if (i == bytes.size() - 1)
                checkOutput("done_early", 32'(done), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Pulse reload with a byte on offer; the byte must be refused.
    task automatic doReload(input logic [7:0] stray);
        reload   = 1'b1;
        in_valid = 1'b1;
        in_data  = stray;
        #1;
        checkOutput("reload_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reload   = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("reload_done", 32'(done), 32'd0);
        checkOutput("reload_error", 32'(error), 32'd0);
        checkOutput("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("reload_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Build a stream from a header and word list, predict writes and the
    // final verdict from the format rules, drive it, compare, then reload.
    // force_chk: -1 correct checksum, -2 random wrong checksum, else exact value.
    task automatic runLoad(input logic [15:0] n_hdr, input word_q_t words,
                           input int force_chk, input int gap_pct);
        byte_q_t     stream;
        logic [31:0] exp_q[$];
        logic [15:0] sum;
        logic [15:0] chk;
        bit          hdr_ok;
        bit          exp_done;
        hdr_ok   = (n_hdr != 16'd0) && (int'(n_hdr) <= (1 << ADDR_W) - 1);
        exp_done = 1'b0;
        sum      = 16'd0;
        stream.push_back(n_hdr[15:8]);
        stream.push_back(n_hdr[7:0]);
        if (hdr_ok) begin
            for (int i = 0; i < int'(n_hdr); i++) begin
                sum = sum + words[i];
                stream.push_back(words[i][15:8]);
                stream.push_back(words[i][7:0]);
                exp_q.push_back({16'(i), words[i]});
            end
            if (force_chk == -1)      chk = sum;
            else if (force_chk == -2) chk = sum + 16'(1 + $urandom_range(0, 254));
            else                      chk = 16'(force_chk);
            stream.push_back(chk[15:8]);
            stream.push_back(chk[7:0]);
            exp_done = (chk == sum);
        end
        obs_q.delete();
        applyStimulus(stream, gap_pct);
        checkOutput("final_done", 32'(done), 32'(exp_done));
        checkOutput("final_error", 32'(error), 32'(!exp_done));
        checkOutput("final_cpu_reset", 32'(cpu_reset), 32'(!exp_done));
        checkOutput("final_in_ready", 32'(in_ready), 32'd0);
        checkOutput("write_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            checkOutput($sformatf("write%0d", i), obs_q[i], exp_q[i]);
        doReload(8'($urandom));
    endtask

    initial begin
        reset    = 1'b0;
        reload   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset values while reset is held.
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_rom_we", 32'(rom_we), 32'd0);
        checkOutput("rst_rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("rst_rom_data", 32'(rom_data), 32'd0);
        checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("release_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("live_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] normal load");
        tmp_w.delete(); tmp_w.push_back(16'h0010); tmp_w.push_back(16'hE308);
        runLoad(16'd2, tmp_w, -1, 0);

        $display("[TB] checksum mismatch");
        runLoad(16'd2, tmp_w, 'hE319, 0);

        $display("[TB] bad headers");
        tmp_w.delete();
        runLoad(16'h0000, tmp_w, -1, 0);
        runLoad(16'h8000, tmp_w, -1, 0);
        runLoad(16'hFFFF, tmp_w, -1, 0);

        $display("[TB] normal load with input gaps");
        tmp_w.delete(); tmp_w.push_back(16'h0010); tmp_w.push_back(16'hE308);
        runLoad(16'd2, tmp_w, -1, 40);

        $display("[TB] largest legal header");
        tmp_b.delete(); tmp_b.push_back(8'h7F); tmp_b.push_back(8'hFF);
        applyStimulus(tmp_b, 0);
        checkOutput("maxhdr_error", 32'(error), 32'd0);
        checkOutput("maxhdr_in_ready", 32'(in_ready), 32'd1);
        doReload(8'h00);

        $display("[TB] reload mid-load");
        obs_q.delete();
        tmp_b.delete(); tmp_b.push_back(8'h00); tmp_b.push_back(8'h02); tmp_b.push_back(8'h00);
        applyStimulus(tmp_b, 0);
        doReload(8'h10);
        checkOutput("reload_no_writes", 32'(obs_q.size()), 32'd0);
        tmp_w.delete(); tmp_w.push_back(16'hABCD);
        runLoad(16'd1, tmp_w, -1, 0);

        $display("[TB] asynchronous reset mid-load");
        tmp_b.delete();
        tmp_b.push_back(8'h00); tmp_b.push_back(8'h02); tmp_b.push_back(8'h00);
        tmp_b.push_back(8'h10); tmp_b.push_back(8'hE3);
        applyStimulus(tmp_b, 0);
        checkOutput("pre_reset_data", 32'(rom_data), 32'h0010);
        in_valid = 1'b1;
        in_data  = 8'h08;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_rom_we", 32'(rom_we), 32'd0);
        checkOutput("arst_rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("arst_rom_data", 32'(rom_data), 32'd0);
        checkOutput("arst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("arst_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("arst_done", 32'(done), 32'd0);
        checkOutput("arst_error", 32'(error), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("arst_live", 32'(in_ready), 32'd1);
        tmp_w.delete(); tmp_w.push_back(16'h0010); tmp_w.push_back(16'hE308);
        runLoad(16'd2, tmp_w, -1, 20);

        $display("[TB] randomized images");
        for (int iter = 0; iter < 10; iter++) begin
            logic [15:0] n;
            int          chk_mode;
            tmp_w.delete();
            if ($urandom_range(0, 9) == 0) begin
                n = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'(32'h8000 + $urandom_range(0, 32'h7FFF));
            end else begin
                n = 16'($urandom_range(1, 6));
                for (int k = 0; k < int'(n); k++)
                    tmp_w.push_back(16'($urandom));
            end
            chk_mode = ($urandom_range(0, 3) == 0) ? -2 : -1;
            runLoad(n, tmp_w, chk_mode, 30);
        end

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_errors);
        $finish;
    end

endmodule
